foo_share_arbiter: RTL and testbench

Round-robin arbiter that time-shares a single `foo` instance among `NUM_REQ` requesters. Each requester offers an (`a`, `b`) operand pair with a valid/ready handshake. The arbiter captures the winning pair, drives it onto the shared `foo` inputs for a fixed hold window, then acknowledges the requester. It sits in `top` in front of the shared `foo` and replaces the per-requester `foo` instances.

---
 rtl/foo_arb_pkg.sv | 24 ++
 rtl/foo_share_arbiter_rr_pick.sv | 45 ++++
 rtl/foo_share_arbiter.sv | 103 ++++++++++
 tb/tb_foo_share_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/foo_arb_pkg.sv
// Shared types and helpers for the foo round-robin share arbiter.
package foo_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_DRIVE   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_t;

   // Modulo-n add of two indices that are each already below n.
   // One conditional subtract is enough and keeps the wrap explicit
   // for requester counts that are not a power of two.
   function automatic int wrap_idx(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) begin
         return s - n;
      end else begin
         return s;
      end
   endfunction

endpackage

// File: rtl/foo_share_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the
// pointer position lands on bit 0, priority-encode the lowest set bit,
// then rotate the index back into requester numbering.
module rr_pick
   import foo_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDW-1:0]     rr_ptr,
   output logic [IDW-1:0]     pick_id,
   output logic               pick_any
);

   logic [NUM_REQ-1:0] w_rot;
   logic [IDW-1:0]     w_enc;

   // Rotate requests so that requester rr_ptr sits at position 0
   always_comb begin
      w_rot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_rot[i] = req_valid[IDW'(wrap_idx(i, int'(rr_ptr), NUM_REQ))];
      end
   end

   // Lowest set bit of the rotated vector wins (scan high to low, last hit sticks)
   always_comb begin
      w_enc = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_enc = IDW'(i);
         end else begin
            w_enc = w_enc;
         end
      end
   end

   // Map the rotated index back to a requester number
   always_comb begin
      pick_any = |req_valid;
      pick_id  = IDW'(wrap_idx(int'(w_enc), int'(rr_ptr), NUM_REQ));
   end

endmodule

// File: rtl/foo_share_arbiter.sv
// Round-robin arbiter time-sharing one foo instance among NUM_REQ
// requesters. A winner's operands are captured once, held on the foo
// inputs for HOLD_CYCLES, then the winner gets a one-cycle ready pulse.
module foo_share_arbiter
   import foo_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int HOLD_CYCLES = 2,
   localparam int IDW         = $clog2(NUM_REQ),
   localparam int HCW         = $clog2(HOLD_CYCLES + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [NUM_REQ-1:0] req_a,
   input  logic [NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0] req_ready,
   output logic               foo_a,
   output logic               foo_b,
   output logic               busy,
   output logic [IDW-1:0]     grant_id
);

   arb_state_t         r_state;
   logic [HCW-1:0]     r_hold_cnt;
   logic [IDW-1:0]     r_rr_ptr;
   logic [IDW-1:0]     r_grant_id;
   logic [NUM_REQ-1:0] r_req_ready;
   logic               r_foo_a;
   logic               r_foo_b;
   logic               r_busy;

   logic [IDW-1:0]     w_pick_id;
   logic               w_pick_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_valid (req_valid),
      .rr_ptr    (r_rr_ptr),
      .pick_id   (w_pick_id),
      .pick_any  (w_pick_any)
   );

   // Grant FSM with hold counter, fairness pointer and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_hold_cnt  <= '0;
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_req_ready <= '0;
         r_foo_a     <= 1'b0;
         r_foo_b     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // ready is a single-cycle pulse; only the DRIVE exit raises it
         r_req_ready <= '0;
         case (r_state)
            ARB_IDLE: begin
               if (w_pick_any) begin
                  r_grant_id <= w_pick_id;
                  r_foo_a    <= req_a[w_pick_id];
                  r_foo_b    <= req_b[w_pick_id];
                  r_hold_cnt <= HCW'(HOLD_CYCLES - 1);
                  r_busy     <= 1'b1;
                  r_state    <= ARB_DRIVE;
               end else begin
                  r_state    <= ARB_IDLE;
               end
            end
            ARB_DRIVE: begin
               if (r_hold_cnt == '0) begin
                  r_req_ready[r_grant_id] <= 1'b1;
                  r_state                 <= ARB_RELEASE;
               end else begin
                  r_hold_cnt <= r_hold_cnt - HCW'(1);
               end
            end
            ARB_RELEASE: begin
               if (r_grant_id == IDW'(NUM_REQ - 1)) begin
                  r_rr_ptr <= '0;
               end else begin
                  r_rr_ptr <= r_grant_id + IDW'(1);
               end
               r_busy  <= 1'b0;
               r_state <= ARB_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign foo_a     = r_foo_a;
   assign foo_b     = r_foo_b;
   assign busy      = r_busy;
   assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_foo_share_arbiter.sv
// Directed bench for foo_share_arbiter (NUM_REQ=4 main instance, plus a
// NUM_REQ=3 instance to exercise explicit pointer wrap).
module tb_foo_share_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] rv, ra, rb;
   logic [3:0] ready;
   logic       foo_a, foo_b, busy;
   logic [1:0] gid;

   logic       rst3;
   logic [2:0] rv3, ra3, rb3;
   logic [2:0] ready3;
   logic       foo_a3, foo_b3, busy3;
   logic [1:0] gid3;

   int n_checks = 0;
   int n_errors = 0;
   int exp_id;

   always #5 clk = ~clk;

   foo_share_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst), .req_valid(rv), .req_a(ra), .req_b(rb),
      .req_ready(ready), .foo_a(foo_a), .foo_b(foo_b), .busy(busy), .grant_id(gid)
   );

   foo_share_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(2)) u_dut3 (
      .clk(clk), .rst(rst3), .req_valid(rv3), .req_a(ra3), .req_b(rb3),
      .req_ready(ready3), .foo_a(foo_a3), .foo_b(foo_b3), .busy(busy3), .grant_id(gid3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rst3 = 1'b1;
      rv = 4'b0000; ra = 4'b0000; rb = 4'b0000;
      rv3 = 3'b000; ra3 = 3'b000; rb3 = 3'b000;

      // reset: 3 cycles
      step(3);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_foo_a", 32'(foo_a), 32'h0);
      chk("rst_foo_b", 32'(foo_b), 32'h0);
      chk("rst_busy",  32'(busy),  32'h0);
      chk("rst_gid",   32'(gid),   32'h0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("idle_busy",  32'(busy),  32'h0);
         chk("idle_ready", 32'(ready), 32'h0);
      end

      // full contention: grants 0,1,2,3,0 every 4 cycles
      rv = 4'b1111; ra = 4'b0101; rb = 4'b1010;
      for (int g = 0; g < 5; g++) begin
         exp_id = g % 4;
         step(1);
         chk("fc_gid",   32'(gid),   32'(exp_id));
         chk("fc_busy",  32'(busy),  32'h1);
         chk("fc_foo_a", 32'(foo_a), (exp_id % 2 == 0) ? 32'h1 : 32'h0);
         chk("fc_foo_b", 32'(foo_b), (exp_id % 2 == 0) ? 32'h0 : 32'h1);
         step(2);
         chk("fc_ready", 32'(ready), 32'h1 << exp_id);
         chk("fc_busy_rel", 32'(busy), 32'h1);
         if (g == 4) begin
            rv = 4'b0000;
         end
         step(1);
         chk("fc_idle_ready", 32'(ready), 32'h0);
         chk("fc_idle_busy",  32'(busy),  32'h0);
      end

      // single request from requester 2
      rv = 4'b0100; ra = 4'b0100; rb = 4'b0000;
      step(1);
      chk("sr_gid",   32'(gid),   32'h2);
      chk("sr_foo_a", 32'(foo_a), 32'h1);
      chk("sr_foo_b", 32'(foo_b), 32'h0);
      chk("sr_busy",  32'(busy),  32'h1);
      chk("sr_ready0", 32'(ready), 32'h0);
      step(1);
      chk("sr_ready1", 32'(ready), 32'h0);
      chk("sr_foo_a1", 32'(foo_a), 32'h1);
      step(1);
      chk("sr_ready", 32'(ready), 32'h4);
      chk("sr_busy_rel", 32'(busy), 32'h1);
      // wrap: pointer now 3, requesters 3 and 0 compete
      rv = 4'b1001; ra = 4'b1000; rb = 4'b0001;
      step(1);
      chk("sr_idle_ready", 32'(ready), 32'h0);
      chk("sr_idle_busy",  32'(busy),  32'h0);
      chk("sr_idle_foo_a", 32'(foo_a), 32'h1);
      chk("sr_idle_gid",   32'(gid),   32'h2);
      step(1);
      chk("wr_gid3",   32'(gid),   32'h3);
      chk("wr_foo_a3", 32'(foo_a), 32'h1);
      chk("wr_foo_b3", 32'(foo_b), 32'h0);
      step(2);
      chk("wr_ready3", 32'(ready), 32'h8);
      rv = 4'b0001;
      step(1);
      chk("wr_idle_busy", 32'(busy), 32'h0);
      step(1);
      chk("wr_gid0",   32'(gid),   32'h0);
      chk("wr_foo_a0", 32'(foo_a), 32'h0);
      chk("wr_foo_b0", 32'(foo_b), 32'h1);
      // operand change and valid drop after the grant
      ra = 4'b1001; rv = 4'b0000;
      step(1);
      chk("oc_foo_a", 32'(foo_a), 32'h0);
      chk("oc_busy",  32'(busy),  32'h1);
      step(1);
      chk("oc_ready", 32'(ready), 32'h1);
      chk("oc_foo_a2", 32'(foo_a), 32'h0);
      step(1);
      chk("oc_ready_end", 32'(ready), 32'h0);
      chk("oc_busy_end",  32'(busy),  32'h0);

      // mid-operation reset (pointer is 1 here, so requester 2 wins)
      rv = 4'b0100; ra = 4'b0100; rb = 4'b0100;
      step(1);
      chk("mr_gid",  32'(gid),  32'h2);
      chk("mr_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      step(1);
      chk("mr_busy0",  32'(busy),  32'h0);
      chk("mr_gid0",   32'(gid),   32'h0);
      chk("mr_foo_a0", 32'(foo_a), 32'h0);
      chk("mr_foo_b0", 32'(foo_b), 32'h0);
      chk("mr_ready0", 32'(ready), 32'h0);
      rst = 1'b0; rv = 4'b0000;
      step(1);
      chk("mr_no_pulse", 32'(ready), 32'h0);
      chk("mr_idle",     32'(busy),  32'h0);
      // pointer must be back at 0: requester 0 beats requester 1
      rv = 4'b0011; ra = 4'b0010; rb = 4'b0001;
      step(1);
      chk("mr_gid_p0", 32'(gid),   32'h0);
      chk("mr_foo_a",  32'(foo_a), 32'h0);
      chk("mr_foo_b",  32'(foo_b), 32'h1);
      step(2);
      chk("mr_ready_p0", 32'(ready), 32'h1);
      rv = 4'b0010;
      step(1);
      chk("mr_idle2", 32'(busy), 32'h0);
      step(1);
      chk("mr_gid1",   32'(gid),   32'h1);
      chk("mr_foo_a1", 32'(foo_a), 32'h1);
      chk("mr_foo_b1", 32'(foo_b), 32'h0);
      step(2);
      chk("mr_ready1", 32'(ready), 32'h2);
      rv = 4'b0000;
      step(1);
      chk("mr_end_busy",  32'(busy),  32'h0);
      chk("mr_end_ready", 32'(ready), 32'h0);

      // NUM_REQ=3: rotation 0,1,2,0,1,2 with the pointer never reaching 3
      rv3 = 3'b111; ra3 = 3'b101; rb3 = 3'b010;
      rst3 = 1'b0;
      for (int g = 0; g < 6; g++) begin
         exp_id = g % 3;
         step(1);
         chk("n3_gid",   32'(gid3),   32'(exp_id));
         chk("n3_foo_a", 32'(foo_a3), (exp_id == 1) ? 32'h0 : 32'h1);
         step(2);
         chk("n3_ready", 32'(ready3), 32'h1 << exp_id);
         step(1);
         chk("n3_idle", 32'(busy3), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
